// File: rtl/if_pkg.sv
// Shared IF-stage types: fetch entry payload and instruction-width constants.
package if_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with clear and a head read
// straight from the storage registers (no fall-through from the write port).
module fetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Clear has priority over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    a_no_push_full: assert property (@(posedge clk) disable iff (rst || clear)
        !(push && (count == CW'(DEPTH))))
        else $error("fetch_fifo: push while full");

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst || clear)
        !(pop && (count == '0)))
        else $error("fetch_fifo: pop while empty");

endmodule

// File: rtl/instr_fetch_buffer.sv
// IF stage: issues PC reads to 1-cycle instruction memory under a credit
// limit and queues {instr, pc} for the ID stage; flush drops all work.
module instr_fetch_buffer
    import if_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned IMEM_AW = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               pc_i,
    input  logic                      pc_valid_i,
    output logic                      pc_ready_o,
    output logic                      imem_req_o,
    output logic [IMEM_AW-1:0]        imem_addr_o,
    input  logic [31:0]               imem_rdata_i,
    input  logic                      flush_i,
    output logic                      id_valid_o,
    input  logic                      id_ready_i,
    output logic [31:0]               id_instr_o,
    output logic [31:0]               id_pc_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              inflight_q;
    logic [XLEN-1:0]   pc_q;
    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic              credit;
    logic              fire;
    logic              push;
    logic              pop;
    fetch_entry_t      wentry;
    fetch_entry_t      head;

    // A slot is reserved at issue time, so queued plus in-flight bounds the FIFO.
    assign occupancy  = {1'b0, count} + (CW+1)'(inflight_q);
    assign credit     = occupancy < (CW+1)'(DEPTH);
    assign pc_ready_o = !rst && !flush_i && credit;
    assign fire       = pc_valid_i && pc_ready_o;

    assign imem_req_o  = fire;
    assign imem_addr_o = pc_i[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            inflight_q <= fire;
            if (fire) begin
                pc_q <= pc_i;
            end
        end
    end

    assign push   = inflight_q && !flush_i && !rst;
    assign pop    = id_valid_o && id_ready_i;
    assign wentry = '{instr: imem_rdata_i, pc: pc_q};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .wdata (wentry),
        .head  (head),
        .count (count)
    );

    assign id_valid_o = (count != '0);
    assign id_instr_o = head.instr;
    assign id_pc_o    = head.pc;
    assign count_o    = count;

endmodule
